// File: rtl/csr_trap_unit.sv
// csr_trap_unit: commit-side machine-mode CSR file, trap entry and MRET.
//
// Holds mstatus/mtvec/mepc/mcause/mscratch plus read-only misa and mhartid.
// At commit it performs the CSR read-modify-write, takes a trap or executes
// MRET. A trap or MRET raises a redirect to fetch. The redirect is held with
// a stable target until fetch accepts it. While the redirect is pending, all
// committing inputs are ignored.
//
// Optional build macro: CSR_COUNTERS_EN adds the 64-bit mcycle/minstret
// counters at B00/B80 and B02/B82. Without it those addresses are unmapped
// and raise an illegal-instruction trap.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wb_*               commit-stage instruction info (valid, pc, exception,
//                      mret, csr op/addr/wdata/src_zero)
//   priv_in            current privilege, captured into MPP on trap
//   csr_rdata          pre-write CSR value (combinational)
//   exception/mret_out single-cycle pulses in the commit cycle
//   mstatus            registered mstatus
//   redirect_valid/pc  redirect request to fetch; redirect_ready accepts it
//   flush              pipeline kill, equal to redirect_valid
module csr_trap_unit #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] MISA_VALUE  = 32'h4000_1100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_valid,
  input  logic [DATA_WIDTH-1:0] wb_pc,
  input  logic                  wb_exc_valid,
  input  logic [DATA_WIDTH-1:0] wb_exc_cause,
  input  logic                  wb_is_mret,
  input  logic                  wb_is_csr,
  input  logic [2:0]            wb_csr_op,
  input  logic [11:0]           wb_csr_addr,
  input  logic [DATA_WIDTH-1:0] wb_csr_wdata,
  input  logic                  wb_csr_src_zero,
  input  logic [1:0]            priv_in,
  output logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  exception,
  output logic                  mret_out,
  output logic [DATA_WIDTH-1:0] mstatus,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ready,
  output logic                  flush
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_REDIR = 1'b1;

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
`endif

  localparam logic [DATA_WIDTH-1:0] CAUSE_ILLEGAL = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK    = ~DATA_WIDTH'(3);

  logic [0:0]            state;
  logic                  mie, mpie;
  logic [1:0]            mpp;
  logic [DATA_WIDTH-1:0] mtvec, mepc, mcause, mscratch, redir_pc_q;
`ifdef CSR_COUNTERS_EN
  logic [DATA_WIDTH-1:0] mcycle_lo, mcycle_hi, minstret_lo, minstret_hi;
`endif

  logic                  commit, csr_mapped, csr_ro, wr_attempt, csr_illegal, csr_we;
  logic [DATA_WIDTH-1:0] csr_old, csr_new, trap_cause;
  logic                  unused_op2;

  // Immediate and register forms behave identically here; only op[1:0] matters.
  assign unused_op2 = wb_csr_op[2];

  always_comb begin
    mstatus        = '0;
    mstatus[3]     = mie;
    mstatus[7]     = mpie;
    mstatus[12:11] = mpp;
  end

  always_comb begin
    csr_mapped = 1'b1;
    csr_old    = '0;
    case (wb_csr_addr)
      A_MSTATUS:   csr_old = mstatus;
      A_MISA:      csr_old = MISA_VALUE;
      A_MTVEC:     csr_old = mtvec;
      A_MSCRATCH:  csr_old = mscratch;
      A_MEPC:      csr_old = mepc;
      A_MCAUSE:    csr_old = mcause;
      A_MHARTID:   csr_old = '0;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE:    csr_old = mcycle_lo;
      A_MCYCLEH:   csr_old = mcycle_hi;
      A_MINSTRET:  csr_old = minstret_lo;
      A_MINSTRETH: csr_old = minstret_hi;
`endif
      default:     csr_mapped = 1'b0;
    endcase
  end

  // RW forms always write; set/clear forms write only with a nonzero source.
  assign wr_attempt = (wb_csr_op[1:0] == 2'b01) | ~wb_csr_src_zero;
  assign csr_ro     = (wb_csr_addr[11:10] == 2'b11);

  always_comb begin
    case (wb_csr_op[1:0])
      2'b01:   csr_new = wb_csr_wdata;
      2'b10:   csr_new = csr_old | wb_csr_wdata;
      2'b11:   csr_new = csr_old & ~wb_csr_wdata;
      default: csr_new = csr_old;
    endcase
  end

  assign commit      = wb_valid & (state == S_IDLE);
  assign csr_illegal = wb_is_csr & (~csr_mapped | (csr_ro & wr_attempt));
  assign exception   = commit & (wb_exc_valid | csr_illegal);
  assign mret_out    = commit & wb_is_mret & ~exception;
  assign csr_we      = commit & wb_is_csr & ~wb_is_mret & ~exception & wr_attempt;
  assign trap_cause  = csr_illegal ? CAUSE_ILLEGAL : wb_exc_cause;
  assign csr_rdata   = csr_old;

  assign redirect_valid = (state == S_REDIR);
  assign redirect_pc    = redir_pc_q;
  assign flush          = redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mie        <= 1'b0;
      mpie       <= 1'b0;
      mpp        <= 2'b11;
      mtvec      <= MTVEC_RESET & ALIGN_MASK;
      mepc       <= '0;
      mcause     <= '0;
      mscratch   <= '0;
      redir_pc_q <= '0;
    end else begin
      if (exception) begin
        mepc       <= wb_pc & ALIGN_MASK;
        mcause     <= trap_cause;
        mpie       <= mie;
        mie        <= 1'b0;
        mpp        <= priv_in;
        redir_pc_q <= mtvec & ALIGN_MASK;
        state      <= S_REDIR;
      end else if (mret_out) begin
        mie        <= mpie;
        mpie       <= 1'b1;
        mpp        <= 2'b00;
        redir_pc_q <= mepc;
        state      <= S_REDIR;
      end else if (csr_we) begin
        case (wb_csr_addr)
          A_MSTATUS: begin
            mie  <= csr_new[3];
            mpie <= csr_new[7];
            // MPP holds only M or U; S/H encodings leave it unchanged.
            if (csr_new[12:11] == 2'b00 || csr_new[12:11] == 2'b11)
              mpp <= csr_new[12:11];
          end
          A_MTVEC:    mtvec    <= csr_new & ALIGN_MASK;
          A_MSCRATCH: mscratch <= csr_new;
          A_MEPC:     mepc     <= csr_new & ALIGN_MASK;
          A_MCAUSE:   mcause   <= csr_new;
          default: ;
        endcase
      end

      if (state == S_REDIR && redirect_ready)
        state <= S_IDLE;
    end
  end

`ifdef CSR_COUNTERS_EN
  logic instret_inc;
  assign instret_inc = commit & ~exception;

  // A written half takes the CSR value; an unwritten hi still absorbs the lo carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_lo   <= '0;
      mcycle_hi   <= '0;
      minstret_lo <= '0;
      minstret_hi <= '0;
    end else begin
      mcycle_lo <= (csr_we && wb_csr_addr == A_MCYCLE) ? csr_new : mcycle_lo + 1'b1;
      mcycle_hi <= (csr_we && wb_csr_addr == A_MCYCLEH) ? csr_new
                 : mcycle_hi + DATA_WIDTH'(&mcycle_lo);
      minstret_lo <= (csr_we && wb_csr_addr == A_MINSTRET) ? csr_new
                   : minstret_lo + DATA_WIDTH'(instret_inc);
      minstret_hi <= (csr_we && wb_csr_addr == A_MINSTRETH) ? csr_new
                   : minstret_hi + DATA_WIDTH'(instret_inc & (&minstret_lo));
    end
  end
`endif

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;
  localparam logic [31:0] MTV_RST = 32'h0000_0040;
  localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;

  logic        clk = 1'b0, rst = 1'b1;
  logic        wb_valid = 0, wb_exc_valid = 0, wb_is_mret = 0, wb_is_csr = 0, wb_csr_src_zero = 0;
  logic [31:0] wb_pc = 0, wb_exc_cause = 0, wb_csr_wdata = 0;
  logic [2:0]  wb_csr_op = 0;
  logic [11:0] wb_csr_addr = 0;
  logic [1:0]  priv_in = 2'b11;
  logic        redirect_ready = 0;
  logic [31:0] csr_rdata, mstatus, redirect_pc;
  logic        exception, mret_out, redirect_valid, flush;

  csr_trap_unit #(.DATA_WIDTH(32), .MTVEC_RESET(MTV_RST), .MISA_VALUE(32'h4000_1100)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_exc_valid(wb_exc_valid),
    .wb_exc_cause(wb_exc_cause), .wb_is_mret(wb_is_mret), .wb_is_csr(wb_is_csr),
    .wb_csr_op(wb_csr_op), .wb_csr_addr(wb_csr_addr), .wb_csr_wdata(wb_csr_wdata),
    .wb_csr_src_zero(wb_csr_src_zero), .priv_in(priv_in), .csr_rdata(csr_rdata),
    .exception(exception), .mret_out(mret_out), .mstatus(mstatus),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush));

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rd;
    logic        exc;
    logic        mret;
    logic [31:0] mst;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] redir_q[$];
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Commit-side monitor: every driven commit slot has one queued expectation.
  exp_t e;
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) chk("unexpected_commit", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        if (e.chk_rd) chk("csr_rdata", csr_rdata, e.rd);
        chk("exception", {31'd0, exception}, {31'd0, e.exc});
        chk("mret_out", {31'd0, mret_out}, {31'd0, e.mret});
        chk("mstatus", mstatus, e.mst);
      end
    end
  end

  // Redirect monitor: checks the target on each accepted handshake.
  always @(negedge clk) begin
    if (!rst && redirect_valid && redirect_ready) begin
      if (redir_q.size() == 0) chk("unexpected_redirect", redirect_pc, 32'hxxxx_xxxx);
      else chk("redirect_pc", redirect_pc, redir_q.pop_front());
    end
  end

  task automatic drive(input logic is_csr, input logic [2:0] op, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic sz, input logic exc_v,
                       input logic [31:0] cause, input logic is_mret, input logic [31:0] pc,
                       input logic [1:0] priv, input logic chk_rd, input logic [31:0] rd,
                       input logic e_exc, input logic e_mret, input logic [31:0] e_mst);
    exp_t x;
    wb_valid = 1; wb_is_csr = is_csr; wb_csr_op = op; wb_csr_addr = addr;
    wb_csr_wdata = wdata; wb_csr_src_zero = sz; wb_exc_valid = exc_v; wb_exc_cause = cause;
    wb_is_mret = is_mret; wb_pc = pc; priv_in = priv;
    x.chk_rd = chk_rd; x.rd = rd; x.exc = e_exc; x.mret = e_mret; x.mst = e_mst;
    exp_q.push_back(x);
    @(posedge clk); #1;
    wb_valid = 0; wb_is_csr = 0; wb_exc_valid = 0; wb_is_mret = 0;
  endtask

  task automatic csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                     input logic sz, input logic [31:0] rd, input logic [31:0] mst);
    drive(1, op, addr, wdata, sz, 0, 0, 0, 0, 2'b11, 1, rd, 0, 0, mst);
  endtask

  task automatic csr_trap(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic sz, input logic [31:0] pc, input logic [1:0] priv,
                          input logic [31:0] mst, input logic [31:0] rpc);
    redir_q.push_back(rpc);
    drive(1, op, addr, wdata, sz, 0, 0, 0, pc, priv, 0, 0, 1, 0, mst);
  endtask

  task automatic release_redirect();
    int n = 0;
    while (!redirect_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("redirect_valid_rise", {31'd0, redirect_valid}, 32'd1);
    redirect_ready = 1;
    @(posedge clk); #1;
    redirect_ready = 0;
    chk("redirect_drop", {31'd0, redirect_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    // Reset state
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_mstatus", mstatus, 32'h0000_1800);
    csr(RS, 12'h300, 0, 1, 32'h0000_1800, 32'h1800);
    csr(RS, 12'h305, 0, 1, MTV_RST, 32'h1800);
    csr(RS, 12'h301, 0, 1, 32'h4000_1100, 32'h1800);

    // mscratch read-modify-write
    csr(RW, 12'h340, 32'hDEAD_BEEF, 0, 32'h0, 32'h1800);
    csr(RS, 12'h340, 32'h0000_FFFF, 1, 32'hDEAD_BEEF, 32'h1800);
    csr(RC, 12'h340, 32'h0000_000F, 0, 32'hDEAD_BEEF, 32'h1800);
    csr(RS, 12'h340, 0, 1, 32'hDEAD_BEE0, 32'h1800);

    // mtvec/mepc low bits read 0, MIE set
    csr(RW, 12'h305, 32'h0000_0103, 0, MTV_RST, 32'h1800);
    csr(RS, 12'h300, 32'h0000_0008, 0, 32'h1800, 32'h1800);
    csr(RW, 12'h341, 32'h0000_2007, 0, 32'h0, 32'h1808);
    csr(RS, 12'h341, 0, 1, 32'h0000_2004, 32'h1808);

    // ecall: trap, held redirect, wb_* ignored while pending
    redir_q.push_back(32'h100);
    drive(0, 0, 0, 0, 0, 1, 32'd11, 0, 32'h2004, 2'b11, 0, 0, 1, 0, 32'h1808);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", {31'd0, redirect_valid}, 32'd1);
      chk("hold_flush", {31'd0, flush}, 32'd1);
      chk("hold_pc", redirect_pc, 32'h100);
      drive(1, RW, 12'h340, 32'h1234, 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 32'h1880);
    end
    release_redirect();
    csr(RS, 12'h341, 0, 1, 32'h2004, 32'h1880);
    csr(RS, 12'h342, 0, 1, 32'd11, 32'h1880);
    csr(RS, 12'h340, 0, 1, 32'hDEAD_BEE0, 32'h1880);

    // MRET: mstatus still pre-update in its own cycle
    csr(RW, 12'h341, 32'h2008, 0, 32'h2004, 32'h1880);
    redir_q.push_back(32'h2008);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h3000, 2'b11, 0, 0, 0, 1, 32'h1880);
    drive(0, 0, 0, 0, 0, 1, 32'd5, 0, 32'h3004, 2'b11, 0, 0, 0, 0, 32'h0088);
    release_redirect();
    csr(RS, 12'h342, 0, 1, 32'd11, 32'h0088);

    // Illegal CSR accesses
    csr_trap(RW, 12'hF14, 32'h55, 0, 32'h3000, 2'b00, 32'h0088, 32'h100);
    release_redirect();
    csr(RS, 12'h342, 0, 1, 32'd2, 32'h0080);
    csr(RS, 12'hF14, 0, 1, 32'd0, 32'h0080);
    csr_trap(RS, 12'h7C0, 0, 1, 32'h3010, 2'b11, 32'h0080, 32'h100);
    release_redirect();
    csr(RS, 12'h342, 0, 1, 32'd2, 32'h1800);
    csr(RS, 12'h341, 0, 1, 32'h3010, 32'h1800);

    // WARL mstatus
    csr(RW, 12'h300, 32'hFFFF_F7FF, 0, 32'h1800, 32'h1800);
    csr(RS, 12'h300, 0, 1, 32'h1888, 32'h1888);
    csr(RW, 12'h300, 32'h0, 0, 32'h1888, 32'h1888);
    csr(RS, 12'h300, 0, 1, 32'h0, 32'h0);

    // Reset while a redirect is pending
    drive(0, 0, 0, 0, 0, 1, 32'd11, 0, 32'h5000, 2'b11, 0, 0, 1, 0, 32'h0);
    chk("pre_rst_redirect", {31'd0, redirect_valid}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("post_rst_redirect", {31'd0, redirect_valid}, 32'd0);
    chk("post_rst_mstatus", mstatus, 32'h1800);
    csr(RS, 12'h305, 0, 1, MTV_RST, 32'h1800);
    csr(RS, 12'h341, 0, 1, 32'h0, 32'h1800);

`ifdef CSR_COUNTERS_EN
    csr(RW, 12'hB00, 32'hFFFF_FFFF, 0, 32'h0, 32'h1800);
    exp_q[exp_q.size()-1].chk_rd = 1'b0;
    @(posedge clk); #1;
    csr(RS, 12'hB80, 0, 1, 32'd1, 32'h1800);
`else
    csr_trap(RS, 12'hB00, 0, 1, 32'h6000, 2'b11, 32'h1800, MTV_RST);
    release_redirect();
    csr(RS, 12'h342, 0, 1, 32'd2, 32'h1800);
`endif

    repeat (2) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("redir_q_drained", redir_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
